mem_access_unit: RTL

//   Load/store front-end between the core datapath and the word-only data memory.

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only data memory: sub-word stores via read-modify-write, extended loads.
// Optional macro MEM_ACCESS_MISALIGN_ERR_EN turns misaligned half/word accesses into error responses.
module mem_access_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_HALF  = 2'b01;
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_q;
  logic [31:0] rsp_rdata_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic        write_r;
  logic        rsp_err_r;
  logic        req_err_s;
  logic        sub_word_s;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lane[1]) h = word[31:16];
    else         h = word[15:0];
    case (size)
      SIZE_BYTE: res = zext ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_HALF: res = zext ? {16'h0000, h} : {{16{h[15]}}, h};
      default:   res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    if (size == SIZE_BYTE) begin
      case (lane)
        2'd0:    res[7:0]   = wdata[7:0];
        2'd1:    res[15:8]  = wdata[7:0];
        2'd2:    res[23:16] = wdata[7:0];
        default: res[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      res[31:16] = wdata[15:0];
    end else begin
      res[15:0] = wdata[15:0];
    end
    return res;
  endfunction

  // Request error decode: range always, alignment only when the option is built in
  always_comb begin
    req_err_s = (req_addr[31:2] >= WORD_LIMIT);
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
    case (req_size)
      SIZE_BYTE: req_err_s = req_err_s;
      SIZE_HALF: req_err_s = req_err_s | req_addr[0];
      default:   req_err_s = req_err_s | (req_addr[1:0] != 2'b00);
    endcase
`endif
  end

  assign sub_word_s = (size_r == SIZE_BYTE) || (size_r == SIZE_HALF);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state and state-decoded memory/handshake outputs
  always_comb begin
    state_s          = state_r;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    mem_address      = 32'h0000_0000;
    mem_write_data   = 32'h0000_0000;
    mem_write_enable = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_s = req_err_s ? RESP : ACCESS;
        else           state_s = IDLE;
      end
      ACCESS: begin
        mem_address = {addr_r[31:2], 2'b00};
        if (write_r && !sub_word_s) begin
          mem_write_enable = 1'b1;
          mem_write_data   = wdata_r;
          state_s          = RESP;
        end else if (write_r) begin
          state_s = MERGE;
        end else begin
          state_s = RESP;
        end
      end
      MERGE: begin
        mem_address      = {addr_r[31:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_write_data   = store_merge(rdata_q, wdata_r, size_r, addr_r[1:0]);
        state_s          = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Request capture, read-data capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      rsp_rdata_r <= 32'h0000_0000;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      write_r     <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            size_r      <= req_size;
            unsigned_r  <= req_unsigned;
            write_r     <= req_write;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= req_err_s;
          end
        end
        ACCESS: begin
          rdata_q <= mem_read_data;
          if (!write_r) rsp_rdata_r <= load_extend(mem_read_data, size_r, addr_r[1:0], unsigned_r);
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
